// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state encoding and the access-legality check
// used by the data-memory responder.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;
   localparam int ADDR_W = 8;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] WAIT_ENC = 2'd1;
   localparam logic [1:0] RESP_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      WAIT = WAIT_ENC,
      RESP = RESP_ENC
   } state_e;

   // True when the byte address is not word aligned or indexes past the storage.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                     input int unsigned       depth);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ({26'd0, addr[ADDR_W-1:2]} >= depth);
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between a load/store
// requester (master) and the data-memory responder (slave).
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with per-byte write enables and a
// registered, write-first read port. Contents survive reset and start at zero.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 64,
   localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
)(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: {WORD_W{1'b0}}};
   logic [WORD_W-1:0] merged_s;
   logic [WORD_W-1:0] rdata_q;

   // Build the post-write word: enabled lanes from wdata, the rest from storage.
   always_comb begin
      merged_s = mem_q[idx_i];
      for (int b = 0; b < BE_W; b++) begin
         if (we_i && be_i[b]) begin
            merged_s[8*b +: 8] = wdata_i[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = mem_q[idx_i][8*b +: 8];
         end
      end
   end

   // Storage update; deliberately outside the reset domain so contents persist.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         mem_q[idx_i] <= merged_s;
      end
   end

   // Read register returns the word as it stands after this access.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= {WORD_W{1'b0}};
      end else if (en_i) begin
         rdata_q <= merged_s;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory target. One request at a time,
// answered WAIT_CYCLES+1 cycles after acceptance; misaligned or out-of-range
// accesses get an error response and leave storage untouched.
// Build macro DMEM_RDBACK_EN: a successful store returns the post-write word.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
)(
   input  logic            SYS_clk,
   input  logic            SYS_reset_n,
   dmem_responder_if.slave bus,
   output logic            busy
);

   localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              accept_s, commit_s, release_s;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;
   logic              err_s;
   logic              keep_on_commit_s;
   logic              rsp_err_q;
   logic              keep_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              busy_q;
   logic [WORD_W-1:0] arr_rdata_s;

   assign err_s = addr_err(addr_q, DEPTH_WORDS);

   // Loads always expose read data; stores only when read-back is built in.
`ifdef DMEM_RDBACK_EN
   assign keep_on_commit_s = ~err_s;
`else
   assign keep_on_commit_s = ~err_s & ~write_q;
`endif

   // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept_s  = 1'b0;
      commit_s  = 1'b0;
      release_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               accept_s = 1'b1;
               cnt_d    = WAIT_INIT;
               state_d  = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               commit_s = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               release_s = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and registered handshake/response outputs.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_err_q   <= 1'b0;
         keep_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= (state_d == IDLE);
         rsp_valid_q <= (state_d == RESP);
         busy_q      <= (state_d != IDLE);
         if (commit_s) begin
            rsp_err_q <= err_s;
            keep_q    <= keep_on_commit_s;
         end else if (release_s) begin
            rsp_err_q <= 1'b0;
            keep_q    <= 1'b0;
         end
      end
   end

   // Capture the request on acceptance; later bus activity cannot disturb it.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         write_q <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {WORD_W{1'b0}};
         be_q    <= {BE_W{1'b0}};
      end else if (accept_s) begin
         write_q <= bus.req_write;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk_i   (SYS_clk),
      .rst_n_i (SYS_reset_n),
      .en_i    (commit_s & ~err_s),
      .we_i    (write_q),
      .idx_i   (addr_q[2 +: IDX_W]),
      .be_i    (be_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata_s)
   );

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = arr_rdata_s & {WORD_W{keep_q}};
   assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven bench for dmem_responder.
// Three instances cover WAIT_CYCLES = 1 (32 words), 4 and 0 (64 words);
// 'sel' routes the shared stimulus to one instance at a time.
module tb_dmem_responder;

`ifdef DMEM_RDBACK_EN
   localparam bit RDBACK = 1'b1;
`else
   localparam bit RDBACK = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_word;   // load data, or post-write word for stores
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  sel;
   logic        req_valid, req_write, rsp_ready;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
   logic [31:0] o_rsp_rdata;
   logic        busy_a, busy_b, busy_c;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dmem_responder_if ifa ();
   dmem_responder_if ifb ();
   dmem_responder_if ifc ();

   assign ifa.req_valid = req_valid & (sel == 2'd0);
   assign ifb.req_valid = req_valid & (sel == 2'd1);
   assign ifc.req_valid = req_valid & (sel == 2'd2);
   assign ifa.rsp_ready = rsp_ready & (sel == 2'd0);
   assign ifb.rsp_ready = rsp_ready & (sel == 2'd1);
   assign ifc.rsp_ready = rsp_ready & (sel == 2'd2);
   assign ifa.req_write = req_write;
   assign ifb.req_write = req_write;
   assign ifc.req_write = req_write;
   assign ifa.req_addr  = req_addr;
   assign ifb.req_addr  = req_addr;
   assign ifc.req_addr  = req_addr;
   assign ifa.req_wdata = req_wdata;
   assign ifb.req_wdata = req_wdata;
   assign ifc.req_wdata = req_wdata;
   assign ifa.req_be    = req_be;
   assign ifb.req_be    = req_be;
   assign ifc.req_be    = req_be;

   dmem_responder #(.DEPTH_WORDS(32), .WAIT_CYCLES(1)) dut_a (
      .SYS_clk(clk), .SYS_reset_n(rst_n), .bus(ifa), .busy(busy_a));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(4)) dut_b (
      .SYS_clk(clk), .SYS_reset_n(rst_n), .bus(ifb), .busy(busy_b));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_c (
      .SYS_clk(clk), .SYS_reset_n(rst_n), .bus(ifc), .busy(busy_c));

   // Route the selected instance's outputs to the checker.
   always_comb begin
      o_req_ready = ifa.req_ready;
      o_rsp_valid = ifa.rsp_valid;
      o_rsp_rdata = ifa.rsp_rdata;
      o_rsp_err   = ifa.rsp_err;
      o_busy      = busy_a;
      case (sel)
         2'd1: begin
            o_req_ready = ifb.req_ready;
            o_rsp_valid = ifb.rsp_valid;
            o_rsp_rdata = ifb.rsp_rdata;
            o_rsp_err   = ifb.rsp_err;
            o_busy      = busy_b;
         end
         2'd2: begin
            o_req_ready = ifc.req_ready;
            o_rsp_valid = ifc.rsp_valid;
            o_rsp_rdata = ifc.rsp_rdata;
            o_rsp_err   = ifc.rsp_err;
            o_busy      = busy_c;
         end
         default: begin
         end
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for rsp_valid; returns the number of negedges waited.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!o_rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "/req_ready"}, 32'(o_req_ready), 32'd1);
      chk({nm, "/rsp_valid"}, 32'(o_rsp_valid), 32'd0);
      chk({nm, "/busy"},      32'(o_busy),      32'd0);
      chk({nm, "/rdata"},     o_rsp_rdata,      32'd0);
      chk({nm, "/err"},       32'(o_rsp_err),   32'd0);
   endtask

   task automatic run_txn(input vec_t v);
      logic [31:0] exp_rd;
      int          lat;
      exp_rd = (v.exp_err || (v.wr && !RDBACK)) ? 32'h0 : v.exp_word;
      @(negedge clk);
      sel       = v.sel;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      #1;
      chk({v.name, "/req_ready"}, 32'(o_req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk({v.name, "/latency"},   lat,              v.exp_lat);
      chk({v.name, "/rdata"},     o_rsp_rdata,      exp_rd);
      chk({v.name, "/err"},       32'(o_rsp_err),   32'(v.exp_err));
      chk({v.name, "/busy"},      32'(o_busy),      32'd1);
      chk({v.name, "/ready_rsp"}, 32'(o_req_ready), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({v.name, "/valid_clr"}, 32'(o_rsp_valid), 32'd0);
      chk({v.name, "/idle_rdy"},  32'(o_req_ready), 32'd1);
   endtask

   vec_t vecs [19];
   vec_t v;
   int   lat;

   initial begin
      // Stores list the post-write word; the bench zeroes it unless read-back is built in.
      vecs[0]  = '{"st08_full",  2'd0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 2};
      vecs[1]  = '{"ld08",       2'd0, 1'b0, 8'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2};
      vecs[2]  = '{"st10_zero",  2'd0, 1'b1, 8'h10, 32'h0,        4'hF, 32'h00000000, 1'b0, 2};
      vecs[3]  = '{"st10_part",  2'd0, 1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 32'h00BB00DD, 1'b0, 2};
      vecs[4]  = '{"ld10",       2'd0, 1'b0, 8'h10, 32'h0,        4'hF, 32'h00BB00DD, 1'b0, 2};
      vecs[5]  = '{"ld06_mis",   2'd0, 1'b0, 8'h06, 32'h0,        4'hF, 32'h0,        1'b1, 2};
      vecs[6]  = '{"ldFC_rng",   2'd0, 1'b0, 8'hFC, 32'h0,        4'hF, 32'h0,        1'b1, 2};
      vecs[7]  = '{"st7C",       2'd0, 1'b1, 8'h7C, 32'h11223344, 4'hF, 32'h11223344, 1'b0, 2};
      vecs[8]  = '{"stFC_rng",   2'd0, 1'b1, 8'hFC, 32'h55667788, 4'hF, 32'h0,        1'b1, 2};
      vecs[9]  = '{"ld7C_keep",  2'd0, 1'b0, 8'h7C, 32'h0,        4'hF, 32'h11223344, 1'b0, 2};
      vecs[10] = '{"st0A_mis",   2'd0, 1'b1, 8'h0A, 32'h0,        4'hF, 32'h0,        1'b1, 2};
      vecs[11] = '{"ld08_keep",  2'd0, 1'b0, 8'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2};
      vecs[12] = '{"st08_be0",   2'd0, 1'b1, 8'h08, 32'hCAFEBABE, 4'h0, 32'hDEADBEEF, 1'b0, 2};
      vecs[13] = '{"ld08_be0",   2'd0, 1'b0, 8'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2};
      vecs[14] = '{"b_st20",     2'd1, 1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0, 5};
      vecs[15] = '{"b_ld20",     2'd1, 1'b0, 8'h20, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 5};
      vecs[16] = '{"c_st04_ff",  2'd2, 1'b1, 8'h04, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 1'b0, 1};
      vecs[17] = '{"c_st04_lo",  2'd2, 1'b1, 8'h04, 32'h0000FFFF, 4'h3, 32'hFFFFFFFF, 1'b0, 1};
      vecs[18] = '{"c_ld04",     2'd2, 1'b0, 8'h04, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0, 1};

      rst_n     = 1'b1;
      sel       = 2'd0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check_idle($sformatf("reset%0d", s));
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         run_txn(vecs[i]);
      end

      // Backpressure: response held 5 cycles, a stray request pulse is ignored.
      @(negedge clk);
      sel = 2'd0; req_write = 1'b0; req_addr = 8'h08; req_be = 4'hF; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("bp/latency", lat, 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d/valid", i), 32'(o_rsp_valid), 32'd1);
         chk($sformatf("bp%0d/rdata", i), o_rsp_rdata,      32'hDEADBEEF);
         chk($sformatf("bp%0d/err", i),   32'(o_rsp_err),   32'd0);
         chk($sformatf("bp%0d/ready", i), 32'(o_req_ready), 32'd0);
         req_valid = (i == 2);
         req_write = 1'b1; req_addr = 8'h08; req_wdata = 32'h0; req_be = 4'hF;
         @(negedge clk);
      end
      req_valid = 1'b1;   // offered in the same cycle the response is taken
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp/no_same_cycle_busy", 32'(o_busy),      32'd0);
      chk("bp/no_same_cycle_rdy",  32'(o_req_ready), 32'd1);
      chk("bp/valid_clr",          32'(o_rsp_valid), 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp/still_idle", 32'(o_busy), 32'd0);
      v = '{"bp_ld08", 2'd0, 1'b0, 8'h08, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 2};
      run_txn(v);

      // Reset during WAIT aborts an uncommitted store.
      @(negedge clk);
      sel = 2'd1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h12345678;
      req_be = 4'hF; req_valid = 1'b1;
      @(posedge clk);           // acceptance
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_idle("rst_wait");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{"rst_ld20", 2'd1, 1'b0, 8'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 5};
      run_txn(v);

      // Reset during RESP drops the pending response.
      @(negedge clk);
      sel = 2'd0; req_write = 1'b0; req_addr = 8'h10; req_be = 4'hF; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("rst_resp/rdata", o_rsp_rdata, 32'h00BB00DD);
      #2 rst_n = 1'b0;
      #1 check_idle("rst_resp");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_resp/after", 32'(o_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
